// File: rtl/bram_porta_ctrl_if.sv
// rtl/bram_porta_ctrl_if.sv - request/response bundle for the BRAM port-A front end
interface bram_porta_ctrl_if #(
  parameter int RAM_WIDTH = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [8:0]           req_addr;
  logic [RAM_WIDTH-1:0] req_data;
  logic                 resp_valid;
  logic [RAM_WIDTH-1:0] resp_data;

  // Requester side: issues requests, receives read responses.
  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, resp_valid, resp_data
  );

  // Controller side: accepts requests, returns read responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bram_porta_ctrl.sv
// rtl/bram_porta_ctrl.sv - port-A sweep-then-serve controller for the resettable BRAM wrapper
module bram_porta_ctrl #(
  parameter int                   RAM_WIDTH  = 16,
  parameter int                   RST_DEPTH  = 16,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 clr,
  output logic                 init_done,
  bram_porta_ctrl_if.slave     bus,
  output logic                 bram_wea,
  output logic [8:0]           bram_addra,
  output logic [RAM_WIDTH-1:0] bram_dina,
  input  logic [RAM_WIDTH-1:0] bram_douta
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [8:0] LAST_ADDR = 9'(RST_DEPTH - 1);
  // After a clr edge has written address 0, the sweep resumes at 1 (or stays at 0 for a one-word sweep).
  localparam logic [8:0] CLR_NEXT  = (RST_DEPTH > 1) ? 9'd1 : 9'd0;

  state_t     state;
  logic [8:0] cnt;
  logic [1:0] rd_pend;
  logic       accept;

  // Requests are only taken in RUN, and never on an edge that is leaving RUN.
  assign bus.req_ready = (state == ST_RUN) & ~clr;
  assign accept        = bus.req_valid & bus.req_ready;

  // Sweep / serve FSM driving the registered BRAM port-A controls.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state      <= ST_INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          bram_wea  <= 1'b1;
          bram_dina <= INIT_VALUE;
          if (clr) begin
            bram_addra <= '0;
            cnt        <= CLR_NEXT;
          end else begin
            bram_addra <= cnt;
            if (cnt == LAST_ADDR) begin
              state     <= ST_RUN;
              init_done <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        ST_RUN: begin
          if (clr) begin
            state     <= ST_INIT;
            init_done <= 1'b0;
            cnt       <= '0;
            bram_wea  <= 1'b0;
          end else if (accept) begin
            bram_wea   <= bus.req_we;
            bram_addra <= bus.req_addr;
            if (bus.req_we) begin
              bram_dina <= bus.req_data;
            end
          end else begin
            bram_wea <= 1'b0;
          end
        end
        default: begin
          state    <= ST_INIT;
          cnt      <= '0;
          bram_wea <= 1'b0;
        end
      endcase
    end
  end

  // Read tracking: address presented for one edge, then douta is captured into the response.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rd_pend        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      rd_pend        <= {rd_pend[0], accept & ~bus.req_we};
      bus.resp_valid <= rd_pend[1];
      if (rd_pend[1]) begin
        bus.resp_data <= bram_douta;
      end
    end
  end

endmodule

// File: tb/tb_bram_porta_ctrl.sv
// tb/tb_bram_porta_ctrl.sv - scoreboard bench for bram_porta_ctrl with a BRAM model
module tb_bram_porta_ctrl;
  localparam int          W  = 16;
  localparam int          D  = 16;
  localparam logic [15:0] IV = 16'hA5A5;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        clr  = 1'b0;
  logic        init_done;
  logic        bram_wea;
  logic [8:0]  bram_addra;
  logic [15:0] bram_dina;
  logic [15:0] bram_douta;

  bram_porta_ctrl_if #(.RAM_WIDTH(W)) bus ();

  bram_porta_ctrl #(.RAM_WIDTH(W), .RST_DEPTH(D), .INIT_VALUE(IV)) dut (
    .clka       (clka),
    .rsta       (rsta),
    .clr        (clr),
    .init_done  (init_done),
    .bus        (bus),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_douta (bram_douta)
  );

  always #5 clka = ~clka;

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 16'h0101) ^ 16'h5A00);
  endfunction

  // BRAM model: synchronous read-first, contents survive rsta.
  logic [15:0] mem [512];
  bit filled = 1'b0;
  always @(posedge clka) begin
    if (!filled) begin
      for (int i = 0; i < 512; i++) mem[i] = init_word(i);
      filled = 1'b1;
    end
    bram_douta <= mem[bram_addra];
    if (bram_wea) mem[bram_addra] <= bram_dina;
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t e;

  // Reference model state
  logic [15:0] ref_mem [512];
  bit          m_run      = 1'b0;
  int          sweep_left = D;
  logic [8:0]  m_addr     = '0;
  logic [15:0] m_din      = '0;

  // Monitor: every resp_valid pops the oldest expected read and checks data and arrival cycle.
  always @(negedge clka) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL resp_missing: got no resp_valid by cycle %0d expected at cycle %0d", cyc, q[0].due);
      void'(q.pop_front());
    end
    if (bus.resp_valid) begin
      if (q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("resp_data", 32'(bus.resp_data), 32'(e.data));
        check("resp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // One clock of stimulus; called just after a falling edge, returns after the next one.
  task automatic cycle(input bit v, input bit we, input logic [8:0] a, input logic [15:0] d, input bit c);
    bit acc;
    bit exp_wea;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_data  = d;
    clr           = c;
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(m_run && !c));
    acc     = v && m_run && !c;
    exp_wea = 1'b0;
    if (m_run) begin
      if (c) begin
        m_run      = 1'b0;
        sweep_left = D;
        for (int i = 0; i < D; i++) ref_mem[i] = IV;
      end else if (acc) begin
        exp_wea = we;
        m_addr  = a;
        if (we) begin
          m_din      = d;
          ref_mem[a] = d;
        end else begin
          q.push_back('{data: ref_mem[a], due: cyc + 3});
        end
      end
    end else begin
      exp_wea = 1'b1;
      m_din   = IV;
      if (c) begin
        m_addr     = '0;
        sweep_left = D - 1;
      end else begin
        m_addr = 9'(D - sweep_left);
        sweep_left--;
        if (sweep_left == 0) m_run = 1'b1;
      end
    end
    @(negedge clka);
    check("bram_wea", 32'(bram_wea), 32'(exp_wea));
    check("bram_addra", 32'(bram_addra), 32'(m_addr));
    if (exp_wea) check("bram_dina", 32'(bram_dina), 32'(m_din));
    check("init_done", 32'(init_done), 32'(m_run));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
  endtask

  task automatic finish_sweep();
    int n = 0;
    while (!m_run && n < 40) begin
      idle(1);
      n++;
    end
    check("sweep_done", 32'(init_done), 32'd1);
  endtask

  task automatic do_reset();
    rsta = 1'b1;
    bus.req_valid = 1'b0;
    clr = 1'b0;
    #1;
    q.delete();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_bram_wea", 32'(bram_wea), 32'd0);
    check("rst_bram_addra", 32'(bram_addra), 32'd0);
    check("rst_bram_dina", 32'(bram_dina), 32'd0);
    m_run      = 1'b0;
    sweep_left = D;
    m_addr     = '0;
    m_din      = '0;
    for (int i = 0; i < D; i++) ref_mem[i] = IV;
    @(negedge clka);
    @(negedge clka);
    rsta = 1'b0;
  endtask

  initial begin
    int nwr;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    @(negedge clka);
    do_reset();
    finish_sweep();

    // Write then read the same word, then an untouched swept word.
    cycle(1'b1, 1'b1, 9'd3, 16'h1234, 1'b0);
    cycle(1'b1, 1'b0, 9'd3, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 9'd7, 16'h0000, 1'b0);
    idle(3);

    // Back-to-back reads.
    cycle(1'b1, 1'b0, 9'd0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 9'd1, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 9'd2, 16'h0, 1'b0);
    idle(3);

    // Read then write to same address: old data comes back.
    cycle(1'b1, 1'b1, 9'd40, 16'hBEEF, 1'b0);
    cycle(1'b1, 1'b0, 9'd40, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 9'd40, 16'hCAFE, 1'b0);
    cycle(1'b1, 1'b0, 9'd40, 16'h0, 1'b0);
    idle(3);

    // Read followed by clr: response still delivered, sweep restarts.
    cycle(1'b1, 1'b1, 9'd5, 16'h5555, 1'b0);
    cycle(1'b1, 1'b0, 9'd5, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 9'd6, 16'h0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 9'd1, 16'h0, 1'b0);

    // clr pulse mid-sweep after addresses 0..8 were written.
    nwr = 0;
    cycle(1'b0, 1'b0, 9'd0, 16'h0, 1'b1);
    if (bram_wea) nwr++;
    for (int i = 0; i < 40 && !init_done; i++) begin
      idle(1);
      if (bram_wea) nwr++;
    end
    check("writes_after_clr", 32'(nwr), 32'(D));
    finish_sweep();

    // clr held: address 0 written repeatedly.
    cycle(1'b0, 1'b0, 9'd0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 9'd2, 16'h0, 1'b1);
    finish_sweep();

    // Randomized traffic over the whole address space.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511)),
            16'($urandom), ($urandom_range(0, 99) < 3));
    end
    finish_sweep();
    idle(3);

    // rsta one cycle after a read accept: the response is dropped.
    cycle(1'b1, 1'b0, 9'd3, 16'h0, 1'b0);
    idle(1);
    do_reset();
    finish_sweep();
    cycle(1'b1, 1'b0, 9'd3, 16'h0, 1'b0);
    idle(5);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
